cpu_multicycle_ctrl: RTL
========================

Name: cpu_multicycle_ctrl

Overview:
Multi-cycle control unit for the 8-bit CPU. It sequences fetch, decode, execute, memory and writeback over the shared single-port memory. It drives the PC, IR, register-file, ALU-source and memory enables. The 2-bit immediate sign extender and the ALU are pure datapath; this block only selects when their results are used.

Parameters:
MEM_TIMEOUT, 15, maximum wait cycles for mem_ready before entering FAULT (1..255)
CNT_W, 8, width of the retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
instr  in  8  current IR contents; op = instr[7:6] (00 add, 01 lw, 10 sw, 11 j)
mem_ready  in  1  memory completion strobe, valid only while mem_req=1
pc_write  out  1  PC load enable
pc_src  out  2  00 = PC+1, 01 = jump target {PC[7:6], instr[5:0]}, others reserved
ir_write  out  1  IR load enable
mem_req  out  1  memory access request
mem_we  out  1  memory write (sw only)
mem_addr_sel  out  1  0 = PC, 1 = ALU result
alu_src_imm  out  1  ALU operand B = sign-extended imm (lw/sw)
reg_write  out  1  register-file write enable
reg_dst  out  1  1 = rd (add), 0 = rt (lw)
mem_to_reg  out  1  writeback data = memory data
state  out  3  current FSM state encoding, for debug
retired  out  CNT_W  count of completed instructions
fault  out  1  sticky memory-timeout flag

Behaviour:
- Reset (async, reset_n=0): state=IDLE, all enables 0, pc_src=00, retired=0, fault=0, op_q=00, wait_cnt=0.
- States and encodings: IDLE 0, FETCH 1, DECODE 2, EXEC 3, MEM 4, WB 5, FAULT 7.
- IDLE: outputs idle for one cycle after reset release, then FETCH.
- FETCH: mem_req=1, mem_addr_sel=0, mem_we=0.
  - On the mem_ready cycle: ir_write=1, pc_write=1, pc_src=00 (Mealy on mem_ready), then DECODE.
  - Otherwise wait_cnt increments.
- DECODE: op_q <= instr[7:6].
  - If op=11: pc_write=1, pc_src=01, retired++, then FETCH.
  - Otherwise go to EXEC.
- EXEC:
  - add: alu_src_imm=0, then WB.
  - lw/sw: alu_src_imm=1, then MEM.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=(op_q==10), alu_src_imm held at 1.
  - On mem_ready, sw: retired++, then FETCH.
  - On mem_ready, lw: go to WB; the memory data register captures data externally.
- WB: reg_write=1.
  - add: reg_dst=1, mem_to_reg=0.
  - lw: reg_dst=0, mem_to_reg=1.
  - Then retired++ and FETCH.
- Timeout:
  - wait_cnt clears on every entry to FETCH or MEM and on mem_ready.
  - If wait_cnt reaches MEM_TIMEOUT with mem_ready still 0, go to FAULT on the next edge.
  - FAULT: all enables 0, fault=1; exit only through reset.
- mem_ready is ignored outside FETCH/MEM, including in the cycle after completion.
- mem_ready=1 on the first cycle of FETCH/MEM is legal and gives a single-cycle access.
- retired wraps modulo 2^CNT_W with no saturation.
- Per-instruction latency with zero-wait memory:
  - j: 2 cycles
  - add: 4 cycles
  - sw: 4 cycles
  - lw: 5 cycles
  - Each memory wait cycle adds one.
- Reset asserted mid-instruction aborts it immediately: no partial reg_write, no retired increment.
- Outputs are combinational from state, op_q and mem_ready. No output depends on instr except in DECODE.

Test Plan:
- Reset, then mem_ready tied to 1 and instr=8'b00_01_10_11 (add) → state 0,1,2,3,5,1; reg_write=1, reg_dst=1 only in WB; retired=1 after 4 post-IDLE cycles.
- lw (instr=8'b01_00_01_10), mem_ready delayed 3 cycles in MEM → mem_addr_sel=1, mem_we=0 for 4 MEM cycles; WB has mem_to_reg=1, reg_dst=0; retired increments once.
- sw (instr=8'b10_00_01_11) → mem_we=1 only in MEM; reg_write never asserts; returns to FETCH after mem_ready.
- j (instr=8'b11_101010) → DECODE asserts pc_write=1 with pc_src=01 for exactly one cycle; next state FETCH.
- MEM_TIMEOUT=15, mem_ready held 0 in FETCH → FAULT (state=7) after 15 wait cycles; fault=1 and all enables 0 indefinitely; reset_n pulse returns to IDLE with fault=0.
- 256 back-to-back j instructions → retired wraps 255→0; reset_n asserted during a lw MEM state → immediate IDLE, reg_write never pulses.

Source files
------------

// File: rtl/cpu_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_multicycle_ctrl
//
// Multi-cycle control unit for the 8-bit CPU. Each instruction is walked
// through fetch, decode, execute, memory and writeback over the one shared
// single-port memory. This block only raises the enables and mux selects;
// the sign extender, ALU, PC and register file live in the datapath.
//
// Parameters:
//   MEM_TIMEOUT  wait cycles tolerated on mem_ready before FAULT (1..255)
//   CNT_W        width of the retired-instruction counter
//
// Ports:
//   clk           system clock, rising edge
//   reset_n       asynchronous active-low reset
//   instr         current IR contents, opcode in instr[7:6]
//                 (00 add, 01 lw, 10 sw, 11 j)
//   mem_ready     memory completion strobe, only looked at in FETCH/MEM
//   pc_write      PC load enable
//   pc_src        PC source: 00 = PC+1, 01 = jump target
//   ir_write      IR load enable
//   mem_req       memory access request
//   mem_we        memory write (sw only)
//   mem_addr_sel  memory address: 0 = PC, 1 = ALU result
//   alu_src_imm   ALU operand B is the sign-extended immediate
//   reg_write     register-file write enable
//   reg_dst       destination register: 1 = rd (add), 0 = rt (lw)
//   mem_to_reg    writeback data comes from memory
//   state         current FSM state encoding, for debug
//   retired       count of completed instructions, wraps
//   fault         sticky memory-timeout flag
// ---------------------------------------------------------------------------
module cpu_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       instr,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             ir_write,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             alu_src_imm,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic             fault
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        FAULT  = 3'd7
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_LW  = 2'b01;
    localparam logic [1:0] OP_SW  = 2'b10;
    localparam logic [1:0] OP_J   = 2'b11;

    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT);

    state_t           state_q;
    state_t           state_d;
    logic [1:0]       op_q;
    logic [1:0]       op_d;
    logic [7:0]       wait_cnt_q;
    logic [7:0]       wait_cnt_d;
    logic [CNT_W-1:0] retired_q;
    logic             retire_now;

    // State register, latched opcode, memory wait counter and retired count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            op_q       <= 2'b00;
            wait_cnt_q <= 8'd0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            wait_cnt_q <= wait_cnt_d;
            if (retire_now) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    // Next-state logic. The wait counter defaults to zero, so it is cleared
    // whenever FETCH/MEM is entered or an access completes; it only counts
    // cycles where a memory access is still outstanding. The timeout fires
    // on a cycle where the counter already sits at the limit and memory is
    // still not ready, so a ready on that very cycle still completes.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        wait_cnt_d = 8'd0;
        retire_now = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (mem_ready) begin
                    state_d = DECODE;
                end else if (wait_cnt_q == WAIT_LIMIT) begin
                    state_d = FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            DECODE: begin
                op_d = instr[7:6];
                if (instr[7:6] == OP_J) begin
                    state_d    = FETCH;
                    retire_now = 1'b1;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                case (op_q)
                    OP_ADD:       state_d = WB;
                    OP_LW, OP_SW: state_d = MEM;
                    default:      state_d = FETCH;
                endcase
            end
            MEM: begin
                if (mem_ready) begin
                    if (op_q == OP_SW) begin
                        state_d    = FETCH;
                        retire_now = 1'b1;
                    end else begin
                        state_d = WB;
                    end
                end else if (wait_cnt_q == WAIT_LIMIT) begin
                    state_d = FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            WB: begin
                state_d    = FETCH;
                retire_now = 1'b1;
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode. Everything comes from the current state and latched
    // opcode, with two exceptions: FETCH completion is Mealy on mem_ready,
    // and the jump in DECODE looks at instr directly because op_q has not
    // been loaded yet in that cycle.
    always_comb begin
        pc_write     = 1'b0;
        pc_src       = 2'b00;
        ir_write     = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        alu_src_imm  = 1'b0;
        reg_write    = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        fault        = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = 2'b00;
                end
            end
            DECODE: begin
                if (instr[7:6] == OP_J) begin
                    pc_write = 1'b1;
                    pc_src   = 2'b01;
                end
            end
            EXEC: begin
                alu_src_imm = (op_q == OP_LW) || (op_q == OP_SW);
            end
            MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (op_q == OP_SW);
                alu_src_imm  = 1'b1;
            end
            WB: begin
                reg_write  = 1'b1;
                reg_dst    = (op_q == OP_ADD);
                mem_to_reg = (op_q == OP_LW);
            end
            FAULT: begin
                fault = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule
